// File: rtl/riscv_mc_controller_if.sv
// Control bus between the multicycle controller and the datapath:
// instruction fields and the ALU Zero flag in, enables and mux selects out.
interface riscv_mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       IllegalInstr;
  logic [3:0] StateOut;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, IllegalInstr, StateOut
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, IllegalInstr, StateOut
  );
endinterface

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control FSM: sequences Fetch/Decode/Execute/Mem/WB and
// drives every datapath enable, mux select and the ALU operation.
module riscv_mc_controller (
  input  logic                  clk,
  input  logic                  reset,
  riscv_mc_controller_if.master bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    s_fetch    = 4'd0,
    s_decode   = 4'd1,
    s_memadr   = 4'd2,
    s_memread  = 4'd3,
    s_memwb    = 4'd4,
    s_memwrite = 4'd5,
    s_executer = 4'd6,
    s_aluwb    = 4'd7,
    s_executei = 4'd8,
    s_jal      = 4'd9,
    s_beq      = 4'd10
  } state_t;

  state_t     state, next;
  logic       pcupdate, branch, adrsrc, memwr, irwr, regwr, illegal;
  logic [1:0] aluop, resultsrc, srca, srcb;
  logic [2:0] aluctl;
  logic [1:0] immsrc;

  always_ff @(posedge clk) begin
    if (reset) state <= s_fetch;
    else       state <= next;
  end

  always_comb begin
    next      = s_fetch;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    aluop     = 2'b00;
    adrsrc    = 1'b0;
    memwr     = 1'b0;
    irwr      = 1'b0;
    regwr     = 1'b0;
    illegal   = 1'b0;
    resultsrc = 2'b00;
    srca      = 2'b00;
    srcb      = 2'b00;
    case (state)
      s_fetch: begin
        irwr      = 1'b1;
        srcb      = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
        next      = s_decode;
      end
      s_decode: begin
        // PC+imm is formed here so BEQ can compare and redirect in one cycle
        srca = 2'b01;
        srcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: next = s_memadr;
          OP_R:         next = s_executer;
          OP_I:         next = s_executei;
          OP_JAL:       next = s_jal;
          OP_BEQ:       next = s_beq;
          default: begin
            next    = s_fetch;
            illegal = 1'b1;
          end
        endcase
      end
      s_memadr: begin
        srca = 2'b10;
        srcb = 2'b01;
        next = (bus.op == OP_LW) ? s_memread : s_memwrite;
      end
      s_memread: begin
        adrsrc = 1'b1;
        next   = s_memwb;
      end
      s_memwb: begin
        resultsrc = 2'b01;
        regwr     = 1'b1;
      end
      s_memwrite: begin
        adrsrc = 1'b1;
        memwr  = 1'b1;
      end
      s_executer: begin
        srca  = 2'b10;
        aluop = 2'b10;
        next  = s_aluwb;
      end
      s_executei: begin
        srca  = 2'b10;
        srcb  = 2'b01;
        aluop = 2'b10;
        next  = s_aluwb;
      end
      s_aluwb: regwr = 1'b1;
      s_jal: begin
        srca     = 2'b01;
        srcb     = 2'b10;
        pcupdate = 1'b1;
        next     = s_aluwb;
      end
      s_beq: begin
        srca   = 2'b10;
        aluop  = 2'b01;
        branch = 1'b1;
      end
      default: next = s_fetch;
    endcase
  end

  // funct7b5 only selects sub for register-register ops; addi ignores it
  always_comb begin
    aluctl = 3'b000;
    case (aluop)
      2'b01: aluctl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  aluctl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  aluctl = 3'b101;
          3'b110:  aluctl = 3'b011;
          3'b111:  aluctl = 3'b010;
          default: aluctl = 3'b000;
        endcase
      end
      default: aluctl = 3'b000;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    case (bus.op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // write enables are squashed during reset so an aborted instruction leaves no trace
  assign bus.PCWrite      = ~reset & (pcupdate | (branch & bus.Zero));
  assign bus.MemWrite     = ~reset & memwr;
  assign bus.IRWrite      = ~reset & irwr;
  assign bus.RegWrite     = ~reset & regwr;
  assign bus.IllegalInstr = ~reset & illegal;
  assign bus.AdrSrc       = adrsrc;
  assign bus.ResultSrc    = resultsrc;
  assign bus.ALUSrcA      = srca;
  assign bus.ALUSrcB      = srcb;
  assign bus.ImmSrc       = immsrc;
  assign bus.ALUControl   = aluctl;
  assign bus.StateOut     = state;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed per-cycle vector bench for riscv_mc_controller plus a hand-written
// reset-during-writeback sequence.
module tb_riscv_mc_controller;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] res, sa, sb, imm;
    logic       rw;
    logic [2:0] alu;
    logic       ill;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   npass = 0;
  int   ntotal = 0;
  vec_t vecs[$];

  riscv_mc_controller_if bus ();

  riscv_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic out_t o(int st, int pcw, int adr, int mw, int irw, int res,
                             int sa, int sb, int imm, int rw, int alu, int ill);
    out_t r;
    r.st  = st[3:0];  r.pcw = pcw[0]; r.adr = adr[0]; r.mw  = mw[0];
    r.irw = irw[0];   r.res = res[1:0]; r.sa = sa[1:0]; r.sb = sb[1:0];
    r.imm = imm[1:0]; r.rw  = rw[0];  r.alu = alu[2:0]; r.ill = ill[0];
    return r;
  endfunction

  task automatic add(string nm, int rst, logic [6:0] op, logic [2:0] f3,
                     int f7, int z, out_t e);
    vec_t v;
    v.name = nm; v.rst = rst[0]; v.op = op; v.f3 = f3;
    v.f7 = f7[0]; v.z = z[0]; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic out_t observe();
    out_t r;
    r.st  = bus.StateOut;  r.pcw = bus.PCWrite;  r.adr = bus.AdrSrc;
    r.mw  = bus.MemWrite;  r.irw = bus.IRWrite;  r.res = bus.ResultSrc;
    r.sa  = bus.ALUSrcA;   r.sb  = bus.ALUSrcB;  r.imm = bus.ImmSrc;
    r.rw  = bus.RegWrite;  r.alu = bus.ALUControl; r.ill = bus.IllegalInstr;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;

    // fields: st pcw adr mw irw res sa sb imm rw alu ill
    add("reset",    1, LW,  3'b010, 0, 0, o(0,0,0,0,0,2,0,2,0,0,0,0));
    add("lw.F",     0, LW,  3'b010, 0, 1, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("lw.D",     0, LW,  3'b010, 0, 1, o(1,0,0,0,0,0,1,1,0,0,0,0));
    add("lw.MA",    0, LW,  3'b010, 0, 1, o(2,0,0,0,0,0,2,1,0,0,0,0));
    add("lw.MR",    0, LW,  3'b010, 0, 1, o(3,0,1,0,0,0,0,0,0,0,0,0));
    add("lw.MWB",   0, LW,  3'b010, 0, 1, o(4,0,0,0,0,1,0,0,0,1,0,0));
    add("sw.F",     0, SW,  3'b010, 0, 0, o(0,1,0,0,1,2,0,2,1,0,0,0));
    add("sw.D",     0, SW,  3'b010, 0, 0, o(1,0,0,0,0,0,1,1,1,0,0,0));
    add("sw.MA",    0, SW,  3'b010, 0, 0, o(2,0,0,0,0,0,2,1,1,0,0,0));
    add("sw.MW",    0, SW,  3'b010, 0, 0, o(5,0,1,1,0,0,0,0,1,0,0,0));
    add("sub.F",    0, RT,  3'b000, 1, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("sub.D",    0, RT,  3'b000, 1, 0, o(1,0,0,0,0,0,1,1,0,0,0,0));
    add("sub.ER",   0, RT,  3'b000, 1, 0, o(6,0,0,0,0,0,2,0,0,0,1,0));
    add("sub.WB",   0, RT,  3'b000, 1, 0, o(7,0,0,0,0,0,0,0,0,1,0,0));
    add("slt.F",    0, RT,  3'b010, 0, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("slt.D",    0, RT,  3'b010, 0, 0, o(1,0,0,0,0,0,1,1,0,0,0,0));
    add("slt.ER",   0, RT,  3'b010, 0, 0, o(6,0,0,0,0,0,2,0,0,0,5,0));
    add("slt.WB",   0, RT,  3'b010, 0, 0, o(7,0,0,0,0,0,0,0,0,1,0,0));
    add("and.F",    0, RT,  3'b111, 1, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("and.D",    0, RT,  3'b111, 1, 0, o(1,0,0,0,0,0,1,1,0,0,0,0));
    add("and.ER",   0, RT,  3'b111, 1, 0, o(6,0,0,0,0,0,2,0,0,0,2,0));
    add("and.WB",   0, RT,  3'b111, 1, 0, o(7,0,0,0,0,0,0,0,0,1,0,0));
    add("addi.F",   0, IT,  3'b000, 1, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("addi.D",   0, IT,  3'b000, 1, 0, o(1,0,0,0,0,0,1,1,0,0,0,0));
    add("addi.EI",  0, IT,  3'b000, 1, 0, o(8,0,0,0,0,0,2,1,0,0,0,0));
    add("addi.WB",  0, IT,  3'b000, 1, 0, o(7,0,0,0,0,0,0,0,0,1,0,0));
    add("ori.F",    0, IT,  3'b110, 0, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("ori.D",    0, IT,  3'b110, 0, 0, o(1,0,0,0,0,0,1,1,0,0,0,0));
    add("ori.EI",   0, IT,  3'b110, 0, 0, o(8,0,0,0,0,0,2,1,0,0,3,0));
    add("ori.WB",   0, IT,  3'b110, 0, 0, o(7,0,0,0,0,0,0,0,0,1,0,0));
    add("beqt.F",   0, BEQ, 3'b000, 0, 1, o(0,1,0,0,1,2,0,2,2,0,0,0));
    add("beqt.D",   0, BEQ, 3'b000, 0, 1, o(1,0,0,0,0,0,1,1,2,0,0,0));
    add("beqt.B",   0, BEQ, 3'b000, 0, 1, o(10,1,0,0,0,0,2,0,2,0,1,0));
    add("beqn.F",   0, BEQ, 3'b000, 0, 0, o(0,1,0,0,1,2,0,2,2,0,0,0));
    add("beqn.D",   0, BEQ, 3'b000, 0, 0, o(1,0,0,0,0,0,1,1,2,0,0,0));
    add("beqn.B",   0, BEQ, 3'b000, 0, 0, o(10,0,0,0,0,0,2,0,2,0,1,0));
    add("jal.F",    0, JAL, 3'b000, 0, 1, o(0,1,0,0,1,2,0,2,3,0,0,0));
    add("jal.D",    0, JAL, 3'b000, 0, 1, o(1,0,0,0,0,0,1,1,3,0,0,0));
    add("jal.J",    0, JAL, 3'b000, 0, 1, o(9,1,0,0,0,0,1,2,3,0,0,0));
    add("jal.WB",   0, JAL, 3'b000, 0, 1, o(7,0,0,0,0,0,0,0,3,1,0,0));
    add("ill.F",    0, BAD, 3'b000, 0, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));
    add("ill.D",    0, BAD, 3'b000, 0, 0, o(1,0,0,0,0,0,1,1,0,0,0,1));
    add("swr.F",    0, SW,  3'b010, 0, 0, o(0,1,0,0,1,2,0,2,1,0,0,0));
    add("swr.D",    0, SW,  3'b010, 0, 0, o(1,0,0,0,0,0,1,1,1,0,0,0));
    add("swr.MA",   0, SW,  3'b010, 0, 0, o(2,0,0,0,0,0,2,1,1,0,0,0));
    add("swr.MWrst",1, SW,  3'b010, 0, 0, o(5,0,1,0,0,0,0,0,1,0,0,0));
    add("post.F",   0, LW,  3'b010, 0, 0, o(0,1,0,0,1,2,0,2,0,0,0,0));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      bus.op = vecs[i].op; bus.funct3 = vecs[i].f3;
      bus.funct7b5 = vecs[i].f7; bus.Zero = vecs[i].z;
      #1;
      chk(vecs[i].name, 32'(observe()), 32'(vecs[i].exp));
    end

    // lw again, reset lands in MemWB: the register write must be squashed
    repeat (4) @(negedge clk);
    chk("rwb.state", 32'(bus.StateOut), 32'd4);
    reset = 1'b1;
    #1;
    chk("rwb.regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    chk("rwb.fetch", 32'(bus.StateOut), 32'd0);
    chk("rwb.irw_held", 32'({bus.IRWrite, bus.PCWrite}), 32'd0);
    reset = 1'b0;
    #1;
    chk("rwb.irw_rel", 32'({bus.IRWrite, bus.PCWrite}), 32'd3);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
Multicycle control unit for the RISC-V core. It is the producer side of the ALU control interface: it drives ALUControl into the ALU and consumes the ALU's Zero flag. It sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states and generates all datapath enables and mux selects. It supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

Parameters:
None.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  instruction opcode, Instr[6:0].
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction and OldPC register enable.
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  SrcA mux: 00 = PC, 01 = OldPC, 10 = register A.
- ALUSrcB  output  2  SrcB mux: 00 = register B, 01 = ImmExt, 10 = constant 4.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  output  1  register file write enable.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- IllegalInstr  output  1  high for one cycle when Decode sees an unsupported opcode.
- StateOut  output  4  current state code, for debug and verification.

Behaviour:
- State codes: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10.
- Reset:
  - While reset is high, PCWrite, MemWrite, IRWrite, RegWrite and IllegalInstr are forced to 0.
  - The state register loads Fetch on the edge where reset is sampled high.
  - Reset asserted mid-instruction aborts that instruction. No partial write occurs in the reset cycle.
- Outputs are Moore in the state, with three exceptions:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ALUControl also depends on op, funct3 and funct7b5.
  - ImmSrc depends only on op.
- Every signal not listed for a state is 0 in that state.
- Per-state outputs and transitions:
  - Fetch: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state is Decode.
  - Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch target).
    - lw or sw goes to MemAdr.
    - 0110011 goes to ExecuteR.
    - 0010011 goes to ExecuteI.
    - 1101111 goes to JAL.
    - 1100011 goes to BEQ.
    - Any other opcode goes to Fetch with IllegalInstr=1 and no architectural writes.
  - MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw (0000011) goes to MemRead; sw (0100011) goes to MemWrite.
  - MemRead: ResultSrc=00, AdrSrc=1. Next state is MemWB.
  - MemWB: ResultSrc=01, RegWrite=1. Next state is Fetch.
  - MemWrite: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is Fetch.
  - ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
  - ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next state is Fetch.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state is Fetch.
- Unused state codes 11–15: all enables 0, next state is Fetch.
- ALU decode (ALUOp is internal):
  - ALUOp 00 gives add; 01 gives sub.
  - ALUOp 10 decodes funct3:
    - 000: sub if op[5] & funct7b5, else add.
    - 010: 101 (slt).
    - 110: 011 (or).
    - 111: 010 (and).
    - Any other funct3: 000.
- ImmSrc by opcode:
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 1101111 gives 11.
  - All other opcodes give 00.
- Latency in cycles, Fetch to the return to Fetch: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- The Zero input is only sampled in BEQ.

Test Plan:
- Reset held for 2 cycles then released: StateOut=0 and IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000 in the first post-reset cycle. All write enables are 0 during reset.
- op=0000011 (lw): StateOut sequence is 0,1,2,3,4 then 0. RegWrite=1 only in state 4, with ResultSrc=01. AdrSrc=1 in state 3.
- op=0110011, funct3=000, funct7b5=1: ExecuteR gives ALUControl=001. With funct3=010, ALUControl=101. With funct3=111, ALUControl=010. op=0010011, funct3=000, funct7b5=1 gives 000 (addi, not sub).
- op=1100011: in BEQ with Zero=1, PCWrite=1. Repeat with Zero=0: PCWrite=0. ALUControl=001 and ImmSrc=10 in both cases. The next state is Fetch after 3 cycles.
- op=1101111 (jal): sequence is 0,1,9,7,0. PCWrite=1 in state 9, RegWrite=1 in state 7, ImmSrc=11.
- op=1111111: Decode drives IllegalInstr=1, then Fetch. Reset asserted in MemWrite gives MemWrite=0 in that cycle and StateOut=0 on the next cycle.
